regfile_wp_arbiter: RTL and testbench

//   Shares the single register-file write port (we3/wa3/wd3) between two

---
 rtl/regfile_wp_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_wp_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wp_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wp_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: lane 0 (ALU/execute) and lane 1 (long-latency load/mul unit).
// Arbitration is round-robin with a combinational valid/ready handshake.
// The winning write is captured into a register that drives the register
// file write port (we3/wa3/wd3) directly. A saturating counter records
// every cycle in which both lanes competed for the port.
//
// Parameters
//   WIDTH  write data width (matches regfile wd3)
//   AW     register address width
//   CNTW   width of the saturating contention counter
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   v0/a0/d0     lane 0 valid, destination register, write data
//   r0           lane 0 ready (combinational grant)
//   v1/a1/d1     lane 1 valid, destination register, write data
//   r1           lane 1 ready (combinational grant)
//   hold         blocks every grant while high
//   we3/wa3/wd3  registered regfile write enable / address / data
//   conflict_cnt cycles in which both lanes were valid and not held
// ---------------------------------------------------------------------------
module regfile_wp_arbiter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v0,
  input  logic [AW-1:0]    a0,
  input  logic [WIDTH-1:0] d0,
  output logic             r0,
  input  logic             v1,
  input  logic [AW-1:0]    a1,
  input  logic [WIDTH-1:0] d1,
  output logic             r1,
  input  logic             hold,
  output logic             we3,
  output logic [AW-1:0]    wa3,
  output logic [WIDTH-1:0] wd3,
  output logic [CNTW-1:0]  conflict_cnt
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Lane-indexed views of the two requesters.
  logic [1:0]       req_valid;
  logic [1:0]       grant;
  logic [AW-1:0]    req_addr [2];
  logic [WIDTH-1:0] req_data [2];

  // Round-robin pointer: the lane that wins the next contended cycle.
  logic             prio_reg;
  logic             prio_next;

  // Write-port output register.
  logic             we_reg;
  logic             we_next;
  logic [AW-1:0]    wa_reg;
  logic [AW-1:0]    wa_next;
  logic [WIDTH-1:0] wd_reg;
  logic [WIDTH-1:0] wd_next;

  // Contention counter.
  logic [CNTW-1:0]  cnt_reg;
  logic [CNTW-1:0]  cnt_next;

  logic             xfer;
  logic             sel;
  logic             contend;

  assign req_valid   = {v1, v0};
  assign req_addr[0] = a0;
  assign req_addr[1] = a1;
  assign req_data[0] = d0;
  assign req_data[1] = d1;

  // A lane is granted when it is valid, nothing is held, and either the
  // other lane is idle or the round-robin pointer names this lane. The two
  // grant terms are mutually exclusive by construction.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign grant[gi] = ~hold & req_valid[gi] &
                         (~req_valid[1-gi] | (prio_reg == 1'(gi)));
    end
  endgenerate

  assign r0 = grant[0];
  assign r1 = grant[1];

  // Ready already implies valid, so a grant is a transfer.
  assign xfer    = |grant;
  assign sel     = grant[1];
  assign contend = v0 & v1 & ~hold;

  always_comb begin
    prio_next = prio_reg;
    we_next   = 1'b0;
    wa_next   = wa_reg;
    wd_next   = wd_reg;
    cnt_next  = cnt_reg;

    if (xfer) begin
      // Point at the lane that just lost (or was idle).
      prio_next = ~sel;
      // Writes to x0 are accepted but never reach the register file.
      we_next   = (req_addr[sel] != '0);
      wa_next   = req_addr[sel];
      wd_next   = req_data[sel];
    end

    if (contend && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg <= 1'b0;
      we_reg   <= 1'b0;
      wa_reg   <= '0;
      wd_reg   <= '0;
      cnt_reg  <= '0;
    end else begin
      prio_reg <= prio_next;
      we_reg   <= we_next;
      wa_reg   <= wa_next;
      wd_reg   <= wd_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign we3          = we_reg;
  assign wa3          = wa_reg;
  assign wd3          = wd_reg;
  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_regfile_wp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wp_arbiter
//
// Directed test of regfile_wp_arbiter. Inputs change on the falling edge;
// the ready outputs are checked combinationally right after, and the
// expected write-port register contents for the next rising edge are pushed
// into a scoreboard queue. A separate monitor pops and compares the write
// port just after every rising edge. A second instance with CNTW=4 covers
// counter saturation.
// ---------------------------------------------------------------------------
module tb_regfile_wp_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0, hold = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        r0, r1, we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [15:0] conflict_cnt;

  // Saturation instance
  logic        bv0 = 1'b0, bv1 = 1'b0;
  logic        br0, br1, bwe3;
  logic [4:0]  bwa3;
  logic [31:0] bwd3;
  logic [3:0]  bcnt;

  int n_tests = 0;
  int n_fail  = 0;
  wr_t sb_q[$];

  always #5 clk = ~clk;

  regfile_wp_arbiter #(.WIDTH(32), .AW(5), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .hold(hold),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .conflict_cnt(conflict_cnt)
  );

  regfile_wp_arbiter #(.WIDTH(32), .AW(5), .CNTW(4)) dut_sat (
    .clk(clk), .reset(reset),
    .v0(bv0), .a0(5'd1), .d0(32'h1), .r0(br0),
    .v1(bv1), .a1(5'd2), .d1(32'h2), .r1(br1),
    .hold(1'b0),
    .we3(bwe3), .wa3(bwa3), .wd3(bwd3),
    .conflict_cnt(bcnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endtask

  // Scoreboard monitor: compares the registered write port after each edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      wr_t e;
      e = sb_q.pop_front();
      check("we3", 64'(we3), 64'(e.we));
      check("wa3", 64'(wa3), 64'(e.wa));
      check("wd3", 64'(wd3), 64'(e.wd));
    end
  end

  // One cycle of stimulus with hand-computed grant and write-port results.
  task automatic step(input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                      input logic iv1, input logic [4:0] ia1, input logic [31:0] id1,
                      input logic ihold,
                      input logic er0, input logic er1,
                      input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd);
    wr_t e;
    @(negedge clk);
    v0 = iv0; a0 = ia0; d0 = id0;
    v1 = iv1; a1 = ia1; d1 = id1;
    hold = ihold;
    #1;
    check("r0", 64'(r0), 64'(er0));
    check("r1", 64'(r1), 64'(er1));
    e.we = ewe; e.wa = ewa; e.wd = ewd;
    sb_q.push_back(e);
  endtask

  // Counter check at the rising edge that closes the current cycle.
  task automatic chk_cnt(input logic [15:0] exp);
    @(posedge clk);
    #2;
    check("conflict_cnt", 64'(conflict_cnt), 64'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    v0 = 1'b0; v1 = 1'b0; hold = 1'b0;
    @(negedge clk);
    check("rst_we3", 64'(we3), 64'd0);
    check("rst_wa3", 64'(wa3), 64'd0);
    check("rst_wd3", 64'(wd3), 64'd0);
    check("rst_cnt", 64'(conflict_cnt), 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // 1: single lane-0 write
    step(1, 5'd5, 32'hA5A5_0001, 0, 5'd0, 32'h0, 0, 1, 0, 1, 5'd5, 32'hA5A5_0001);

    // 2: four contended cycles alternate 0,1,0,1 from reset priority
    do_reset();
    step(1, 5'd1, 32'hD000_0001, 1, 5'd2, 32'hD100_0001, 0, 1, 0, 1, 5'd1, 32'hD000_0001);
    step(1, 5'd1, 32'hD000_0002, 1, 5'd2, 32'hD100_0001, 0, 0, 1, 1, 5'd2, 32'hD100_0001);
    step(1, 5'd1, 32'hD000_0002, 1, 5'd2, 32'hD100_0002, 0, 1, 0, 1, 5'd1, 32'hD000_0002);
    step(1, 5'd1, 32'hD000_0003, 1, 5'd2, 32'hD100_0002, 0, 0, 1, 1, 5'd2, 32'hD100_0002);
    chk_cnt(16'd4);

    // 3: lane-1 write to x0 is accepted but dropped
    step(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 1, 0, 5'd0, 32'hFFFF_FFFF);

    // lane 0 write leaves priority on lane 1
    step(1, 5'd3, 32'h0000_0033, 0, 5'd0, 32'h0, 0, 1, 0, 1, 5'd3, 32'h0000_0033);

    // 4: hold blocks both lanes; wa3/wd3 keep the last write
    step(1, 5'd4, 32'h0000_0044, 1, 5'd6, 32'h0000_0066, 1, 0, 0, 0, 5'd3, 32'h0000_0033);
    step(1, 5'd4, 32'h0000_0044, 1, 5'd6, 32'h0000_0066, 1, 0, 0, 0, 5'd3, 32'h0000_0033);
    step(1, 5'd4, 32'h0000_0044, 1, 5'd6, 32'h0000_0066, 1, 0, 0, 0, 5'd3, 32'h0000_0033);
    chk_cnt(16'd4);
    // release: priority lane 1 wins first
    step(1, 5'd4, 32'h0000_0044, 1, 5'd6, 32'h0000_0066, 0, 0, 1, 1, 5'd6, 32'h0000_0066);
    chk_cnt(16'd5);
    step(1, 5'd4, 32'h0000_0044, 0, 5'd0, 32'h0, 0, 1, 0, 1, 5'd4, 32'h0000_0044);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd4, 32'h0000_0044);

    // 6: transfer then reset on the following edge clears the write and prio
    step(0, 5'd0, 32'h0, 1, 5'd7, 32'h0000_0077, 0, 0, 1, 1, 5'd7, 32'h0000_0077);
    // lane 1 just won, prio now 0; push it to 1 with a lane 0 win first
    step(1, 5'd9, 32'h0000_0099, 0, 5'd0, 32'h0, 0, 1, 0, 1, 5'd9, 32'h0000_0099);
    do_reset();
    // prio back to 0: lane 0 wins the contended cycle
    step(1, 5'd8, 32'h0000_0088, 1, 5'd10, 32'h0000_00AA, 0, 1, 0, 1, 5'd8, 32'h0000_0088);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0, 0, 5'd8, 32'h0000_0088);

    // 5: 4-bit counter saturates at 15
    @(negedge clk);
    bv0 = 1'b1; bv1 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #2;
      if (i == 14) check("sat_cnt_14", 64'(bcnt), 64'd14);
      if (i == 15) check("sat_cnt_15", 64'(bcnt), 64'd15);
      if (i == 20) check("sat_cnt_20", 64'(bcnt), 64'd15);
    end
    bv0 = 1'b0; bv1 = 1'b0;

    @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
